// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the dual-writeback integer register file.
package regfile_pkg;

    localparam int DEF_DATA_W   = 64;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_ZERO_REG = 31;

    typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits for outstanding producers, and the decode stall they imply.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              use1,
    input  logic              use2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_wa,
    output logic              pend1,
    output logic              pend2,
    output logic              stall
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             hit1;
    logic             hit2;

    // Set is applied after clear so a newer producer issued on the same edge keeps the bit.
    always_comb begin
        pending_d = pending_q;
        if (we3) pending_d[wa3] = 1'b0;
        if (we4) pending_d[wa4] = 1'b0;
        if (issue_en && issue_wa != ZERO_A) pending_d[issue_wa] = 1'b1;
        pending_d[ZERO_REG] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) pending_q <= '0;
        else       pending_q <= pending_d;
    end

    // A same-cycle writeback satisfies the reader only when it can be forwarded.
    assign hit1 = (BYPASS != 0) && ((we3 && wa3 == ra1) || (we4 && wa4 == ra1));
    assign hit2 = (BYPASS != 0) && ((we3 && wa3 == ra2) || (we4 && wa4 == ra2));

    assign pend1 = pending_q[ra1] & ~hit1;
    assign pend2 = pending_q[ra2] & ~hit2;
    assign stall = (use1 & pend1) | (use2 & pend2);

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with ALU and load writeback ports, optional forwarding,
// and a pending scoreboard for decode stalls.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = 1,
    parameter int INIT_IDX = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic              use1,
    input  logic              use2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              we4,
    input  logic [ADDR_W-1:0] wa4,
    input  logic [DATA_W-1:0] wd4,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_wa,
    output logic              pend1,
    output logic              pend2,
    output logic              stall
);

    localparam int NREGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] ra,
        input logic [DATA_W-1:0] arr_val,
        input logic              we_a,
        input logic [ADDR_W-1:0] wa_a,
        input logic [DATA_W-1:0] wd_a,
        input logic              we_b,
        input logic [ADDR_W-1:0] wa_b,
        input logic [DATA_W-1:0] wd_b
    );
        if (ra == ZERO_A)                          return '0;
        if (BYPASS != 0 && we_a && wa_a == ra)     return wd_a;
        if (BYPASS != 0 && we_b && wa_b == ra)     return wd_b;
        return arr_val;
    endfunction

    // Port B is applied first so port A overwrites it on an address collision.
    always_comb begin
        regs_d = regs_q;
        if (we4 && wa4 != ZERO_A) regs_d[wa4] = wd4;
        if (we3 && wa3 != ZERO_A) regs_d[wa3] = wd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (INIT_IDX != 0 && i != ZERO_REG) ? DATA_W'(i) : '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = read_port(ra1, regs_q[ra1], we3, wa3, wd3, we4, wa4, wd4);
    assign rd2 = read_port(ra2, regs_q[ra2], we3, wa3, wd3, we4, wa4, wd4);

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_sb (
        .clk      (clk),
        .reset    (reset),
        .ra1      (ra1),
        .ra2      (ra2),
        .use1     (use1),
        .use2     (use2),
        .we3      (we3),
        .wa3      (wa3),
        .we4      (we4),
        .wa4      (wa4),
        .issue_en (issue_en),
        .issue_wa (issue_wa),
        .pend1    (pend1),
        .pend2    (pend2),
        .stall    (stall)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share stimulus;
// expected outputs are queued at drive time and compared after inputs settle.
module tb_regfile_sb;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int ZR = 31;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] ra1, ra2, wa3, wa4, issue_wa;
    logic          use1, use2, we3, we4, issue_en;
    logic [DW-1:0] wd3, wd4;

    logic [DW-1:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic          pend1_b, pend2_b, stall_b, pend1_n, pend2_n, stall_n;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(1), .INIT_IDX(1)) dut_b (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .rd1(rd1_b), .rd2(rd2_b), .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4), .issue_en(issue_en), .issue_wa(issue_wa),
        .pend1(pend1_b), .pend2(pend2_b), .stall(stall_b)
    );

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(ZR), .BYPASS(0), .INIT_IDX(1)) dut_n (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .use1(use1), .use2(use2),
        .rd1(rd1_n), .rd2(rd2_n), .we3(we3), .wa3(wa3), .wd3(wd3),
        .we4(we4), .wa4(wa4), .wd4(wd4), .issue_en(issue_en), .issue_wa(issue_wa),
        .pend1(pend1_n), .pend2(pend2_n), .stall(stall_n)
    );

    typedef struct {
        string         tag;
        int            sig;
        logic [DW-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference state, updated from the same inputs at each rising edge.
    logic [DW-1:0] m_reg [NR];
    logic [NR-1:0] m_pend;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) m_reg[i] = (i == ZR) ? '0 : DW'(i);
            m_pend = '0;
        end else begin
            if (we4 && wa4 != AW'(ZR)) m_reg[wa4] = wd4;
            if (we3 && wa3 != AW'(ZR)) m_reg[wa3] = wd3;
            if (we3) m_pend[wa3] = 1'b0;
            if (we4) m_pend[wa4] = 1'b0;
            if (issue_en && issue_wa != AW'(ZR)) m_pend[issue_wa] = 1'b1;
        end
    end

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] ra, input bit byp);
        if (ra == AW'(ZR))               return '0;
        if (byp && we3 && wa3 == ra)     return wd3;
        if (byp && we4 && wa4 == ra)     return wd4;
        return m_reg[ra];
    endfunction

    function automatic logic m_pd(input logic [AW-1:0] ra, input bit byp);
        return m_pend[ra] & ~(byp & ((we3 && wa3 == ra) || (we4 && wa4 == ra)));
    endfunction

    function automatic logic [DW-1:0] observe(input int sig);
        case (sig)
            0: return rd1_b;
            1: return rd2_b;
            2: return DW'(pend1_b);
            3: return DW'(pend2_b);
            4: return DW'(stall_b);
            5: return rd1_n;
            6: return rd2_n;
            7: return DW'(pend1_n);
            8: return DW'(pend2_n);
            default: return DW'(stall_n);
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic expect_sig(input string tag, input int sig, input logic [DW-1:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
        reset = 1'b0; ra1 = '0; ra2 = '0; use1 = 1'b0; use2 = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; we4 = 1'b0; wa4 = '0; wd4 = '0;
        issue_en = 1'b0; issue_wa = '0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 8) return AW'(ZR);
        if (r == 9) return AW'($urandom_range(0, NR - 1));
        return AW'(r);
    endfunction

    initial begin
        reset = 1'b1; ra1 = '0; ra2 = '0; use1 = 1'b0; use2 = 1'b0;
        we3 = 1'b0; wa3 = '0; wd3 = '0; we4 = 1'b0; wa4 = '0; wd4 = '0;
        issue_en = 1'b0; issue_wa = '0;

        // Reset image after a single reset edge
        next_cycle(); ra1 = 5'd7; ra2 = 5'd31;
        expect_sig("rst_rd1_b", 0, 64'd7);
        expect_sig("rst_rd2_b", 1, 64'd0);
        expect_sig("rst_stall_b", 4, 64'd0);
        expect_sig("rst_rd1_n", 5, 64'd7);
        expect_sig("rst_pend2_n", 8, 64'd0);
        drain();

        // Dual write to the same register: port A wins
        next_cycle(); we3 = 1; wa3 = 5'd4; wd3 = 64'hAA; we4 = 1; wa4 = 5'd4; wd4 = 64'hBB; ra1 = 5'd4;
        expect_sig("dual_byp_b", 0, 64'hAA);
        expect_sig("dual_old_n", 5, 64'd4);
        drain();
        next_cycle(); ra1 = 5'd4;
        expect_sig("dual_arr_b", 0, 64'hAA);
        expect_sig("dual_arr_n", 5, 64'hAA);
        drain();

        // Zero register ignores writes and issues
        next_cycle(); we3 = 1; wa3 = 5'd31; wd3 = 64'hFFFF; ra1 = 5'd31; use1 = 1;
        issue_en = 1; issue_wa = 5'd31;
        expect_sig("zero_rd1_b", 0, 64'd0);
        expect_sig("zero_rd1_n", 5, 64'd0);
        drain();
        next_cycle(); ra1 = 5'd31; use1 = 1;
        expect_sig("zero_rd1_next_b", 0, 64'd0);
        expect_sig("zero_pend_b", 2, 64'd0);
        expect_sig("zero_stall_n", 9, 64'd0);
        drain();

        // Scoreboard stall and load-writeback release
        next_cycle(); issue_en = 1; issue_wa = 5'd5;
        drain();
        next_cycle(); ra1 = 5'd5; use1 = 1;
        expect_sig("sb_stall_b", 4, 64'd1);
        expect_sig("sb_stall_n", 9, 64'd1);
        drain();
        next_cycle(); ra1 = 5'd5; use1 = 1; we4 = 1; wa4 = 5'd5; wd4 = 64'h123;
        expect_sig("sb_wb_pend_b", 2, 64'd0);
        expect_sig("sb_wb_stall_b", 4, 64'd0);
        expect_sig("sb_wb_rd1_b", 0, 64'h123);
        expect_sig("sb_wb_pend_n", 7, 64'd1);
        expect_sig("sb_wb_rd1_n", 5, 64'd5);
        drain();
        next_cycle(); ra1 = 5'd5; use1 = 1;
        expect_sig("sb_clr_pend_b", 2, 64'd0);
        expect_sig("sb_clr_pend_n", 7, 64'd0);
        expect_sig("sb_clr_rd1_n", 5, 64'h123);
        drain();

        // Set/clear race on the same edge: set wins
        next_cycle(); issue_en = 1; issue_wa = 5'd9;
        drain();
        next_cycle(); issue_en = 1; issue_wa = 5'd9; we3 = 1; wa3 = 5'd9; wd3 = 64'h99; ra1 = 5'd9; use1 = 1;
        expect_sig("race_pend_n", 7, 64'd1);
        expect_sig("race_pend_b", 2, 64'd0);
        drain();
        next_cycle(); ra2 = 5'd9; use2 = 1;
        expect_sig("race_after_pend2_b", 3, 64'd1);
        expect_sig("race_after_stall_b", 4, 64'd1);
        expect_sig("race_after_rd2_n", 6, 64'h99);
        drain();

        // Reset dominates a coincident write
        next_cycle(); issue_en = 1; issue_wa = 5'd3; we3 = 1; wa3 = 5'd3; wd3 = 64'h55;
        drain();
        next_cycle(); ra1 = 5'd3;
        expect_sig("mid_rd1_n", 5, 64'h55);
        expect_sig("mid_pend_n", 7, 64'd1);
        drain();
        next_cycle(); reset = 1; we3 = 1; wa3 = 5'd3; wd3 = 64'h77;
        drain();
        next_cycle(); ra1 = 5'd3; use1 = 1;
        expect_sig("mid_rst_rd1_n", 5, 64'd3);
        expect_sig("mid_rst_pend_n", 7, 64'd0);
        expect_sig("mid_rst_stall_b", 4, 64'd0);
        drain();

        // Random traffic against the reference state
        for (int c = 0; c < 400; c++) begin
            next_cycle();
            ra1 = rand_addr(); ra2 = rand_addr();
            use1 = 1'($urandom_range(0, 1)); use2 = 1'($urandom_range(0, 1));
            we3 = 1'($urandom_range(0, 1)); wa3 = rand_addr(); wd3 = {$urandom(), $urandom()};
            we4 = 1'($urandom_range(0, 1)); wa4 = rand_addr(); wd4 = {$urandom(), $urandom()};
            issue_en = 1'($urandom_range(0, 1)); issue_wa = rand_addr();
            reset = ($urandom_range(0, 99) == 0);
            expect_sig("rnd_rd1_b", 0, m_rd(ra1, 1'b1));
            expect_sig("rnd_rd2_b", 1, m_rd(ra2, 1'b1));
            expect_sig("rnd_pend1_b", 2, DW'(m_pd(ra1, 1'b1)));
            expect_sig("rnd_pend2_b", 3, DW'(m_pd(ra2, 1'b1)));
            expect_sig("rnd_stall_b", 4, DW'((use1 & m_pd(ra1, 1'b1)) | (use2 & m_pd(ra2, 1'b1))));
            expect_sig("rnd_rd1_n", 5, m_rd(ra1, 1'b0));
            expect_sig("rnd_rd2_n", 6, m_rd(ra2, 1'b0));
            expect_sig("rnd_pend1_n", 7, DW'(m_pd(ra1, 1'b0)));
            expect_sig("rnd_pend2_n", 8, DW'(m_pd(ra2, 1'b0)));
            expect_sig("rnd_stall_n", 9, DW'((use1 & m_pd(ra1, 1'b0)) | (use2 & m_pd(ra2, 1'b0))));
            drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the single-write-port integer register file.
- Configurable data width and depth, configurable hard-wired zero register.
- Two write ports: ALU writeback and memory/load writeback.
- Optional same-cycle write-to-read bypass.
- Per-register pending scoreboard that drives a decode-stage stall for the pipelined core.

Parameters:
DATA_W, 64, register data width in bits
ADDR_W, 5, register address width; depth NREGS = 2**ADDR_W
ZERO_REG, 31, index of the hard-wired zero register (reads 0, writes ignored)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = array only
INIT_IDX, 1, 1 = reset loads register i with value i; 0 = reset loads all zeros

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ra1  in  ADDR_W  read address, port 1
ra2  in  ADDR_W  read address, port 2
use1  in  1  the decoded instruction consumes ra1
use2  in  1  the decoded instruction consumes ra2
rd1  out  DATA_W  read data, port 1
rd2  out  DATA_W  read data, port 2
we3  in  1  write enable, port A (ALU writeback)
wa3  in  ADDR_W  write address, port A
wd3  in  DATA_W  write data, port A
we4  in  1  write enable, port B (load writeback)
wa4  in  ADDR_W  write address, port B
wd4  in  DATA_W  write data, port B
issue_en  in  1  an instruction with a destination register leaves decode this cycle
issue_wa  in  ADDR_W  destination register of the issuing instruction
pend1  out  1  ra1 has an outstanding producer not satisfied this cycle
pend2  out  1  ra2 has an outstanding producer not satisfied this cycle
stall  out  1  (use1 & pend1) | (use2 & pend2)

Behaviour:
- Clocking and reset:
  - All state updates on posedge clk.
  - reset=1 at an edge dominates all writes and issues that edge.
  - Reset state: reg[i] = (INIT_IDX ? i : 0) for every i != ZERO_REG; reg[ZERO_REG] = 0; all pending bits = 0.
- Outputs are purely combinational from state and inputs, so there is no separate reset value. After reset with INIT_IDX=1 and no writes: rd1 = ra1, rd2 = ra2, except 0 for ZERO_REG; pend1 = pend2 = stall = 0.
- Writes:
  - Port A writes wd3 to reg[wa3] when we3 & wa3 != ZERO_REG. Port B behaves the same with we4/wa4/wd4.
  - Both ports enabled with wa3 == wa4: port A wins; port B data is dropped.
  - Write latency is 1 cycle (visible in the array after the edge).
- Reads, per port p:
  - ra == ZERO_REG -> 0.
  - Else if BYPASS and we3 & wa3 == ra -> wd3.
  - Else if BYPASS and we4 & wa4 == ra -> wd4.
  - Else reg[ra].
  - With BYPASS=0, a read returns the old value in the write cycle.
- Scoreboard (pending[NREGS]):
  - Set: issue_en & issue_wa != ZERO_REG sets pending[issue_wa].
  - Clear: we3 clears pending[wa3]; we4 clears pending[wa4].
  - Set and clear at the same index in the same edge: set wins (a newer producer exists).
  - Issue to an already-pending register leaves it set; single-outstanding model, no counting.
  - pending[ZERO_REG] is always 0.
- pend outputs:
  - pendp = pending[ra] & ~(BYPASS & a same-cycle write to ra on either port).
  - With BYPASS=0, pendp = pending[ra].
- stall: combinational. The decode stage must hold issue_en low while stall=1; this block does not gate issue_en.
- Out-of-range addresses cannot occur, since NREGS = 2**ADDR_W.

Decomposition:
- Package regfile_pkg holds:
  - typedef reg_addr_t (logic [ADDR_W-1:0])
  - typedef reg_data_t (logic [DATA_W-1:0])
  - constants DEF_DATA_W=64, DEF_ADDR_W=5, DEF_ZERO_REG=31
- One sub-module, regfile_scoreboard: pending bit vector, set/clear priority, pend/stall generation.
- Storage, write arbitration and bypass muxes stay in regfile_sb.

Test Plan:
- Reset, INIT_IDX=1: reset=1 for 1 edge, then ra1=7, ra2=31 -> rd1=7, rd2=0; stall=0.
- Dual write conflict: we3=we4=1, wa3=wa4=4, wd3=0xAA, wd4=0xBB; next cycle ra1=4 -> rd1=0xAA. Same cycle with BYPASS=1 -> rd1=0xAA.
- Zero register: we3=1, wa3=31, wd3=0xFFFF -> rd1(ra1=31)=0 the same cycle and the next; issue_en with issue_wa=31 -> pend never set.
- Scoreboard stall: issue_en, issue_wa=5; next cycle ra1=5, use1=1 -> stall=1. Then we4=1, wa4=5, wd4=0x123 -> same cycle pend1=0, stall=0, rd1=0x123. Next cycle pending[5]=0.
- Set/clear race: pending[9]=1; one edge with issue_en, issue_wa=9 and we3=1, wa3=9 -> after the edge pending[9]=1. With BYPASS=0, pend1 stays 1 in the write cycle.
- Reset mid-operation: pending[3]=1, reg[3]=0x55; reset=1 together with we3=1, wa3=3 -> after the edge reg[3]=3, pending[3]=0.
